// File: rtl/coincid_trig_core_if.sv
// Bundle of hit inputs, configuration and trigger outputs for coincid_trig_core.
// The slave modport is the core's view; master is the driving side (FEE / bench).
interface coincid_trig_core_if #(
    parameter int N_CH    = 8,
    parameter int N_GRP   = 5,
    parameter int ALIGN_W = 4,
    parameter int DIV_W   = 6,
    parameter int CNT_W   = 16,
    parameter int DEAD_W  = 8
);
    logic [N_CH-1:0]          hit_a_in_N;
    logic [N_CH-1:0]          hit_b_in_N;
    logic [N_CH-1:0]          hit_ab_sel_in;
    logic [N_CH-1:0]          hit_mask_in;
    logic [N_CH*ALIGN_W-1:0]  hit_align_in;
    logic                     busy_in;
    logic [N_GRP*N_CH-1:0]    grp_mux_in;
    logic [N_GRP-1:0]         grp_oe_in;
    logic [N_GRP*DIV_W-1:0]   grp_div_in;
    logic [DEAD_W-1:0]        trg_dead_time_in;

    logic [N_CH-1:0]          hit_syn_out;
    logic [N_GRP-1:0]         grp_match_out;
    logic                     coincid_trg_out;
    logic [N_GRP-1:0]         coincid_tag_out;
    logic [N_GRP*CNT_W-1:0]   grp_cnt_out;
    logic                     busy_out;

    modport master (
        output hit_a_in_N, hit_b_in_N, hit_ab_sel_in, hit_mask_in, hit_align_in,
               busy_in, grp_mux_in, grp_oe_in, grp_div_in, trg_dead_time_in,
        input  hit_syn_out, grp_match_out, coincid_trg_out, coincid_tag_out,
               grp_cnt_out, busy_out
    );

    modport slave (
        input  hit_a_in_N, hit_b_in_N, hit_ab_sel_in, hit_mask_in, hit_align_in,
               busy_in, grp_mux_in, grp_oe_in, grp_div_in, trg_dead_time_in,
        output hit_syn_out, grp_match_out, coincid_trg_out, coincid_tag_out,
               grp_cnt_out, busy_out
    );
endinterface

// File: rtl/coincid_trig_core.sv
// Coincidence trigger core: per-channel sync/select/mask/stretch, N_GRP AND groups
// with prescalers and raw counters, and a tagged trigger followed by dead time.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for any qualified group event
//   S_TRIG | one-cycle trigger pulse, tag latched
//   S_DEAD | dead-time countdown; holds at zero while busy_in is high
module coincid_trig_core #(
    parameter int N_CH      = 8,
    parameter int N_GRP     = 5,
    parameter int ALIGN_W   = 4,
    parameter int DIV_W     = 6,
    parameter int CNT_W     = 16,
    parameter int DEAD_W    = 8,
    parameter int DEAD_UNIT = 500
) (
    input  logic               clk_in,
    input  logic               rst_in,
    coincid_trig_core_if.slave bus
);
    localparam int DEAD_CW = $clog2((2**DEAD_W - 1) * DEAD_UNIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_TRIG, S_DEAD} state_t;

    logic [N_CH-1:0]    r_s1, r_s2, r_s3;
    logic [N_CH-1:0]    w_sel, w_edge, w_hit_syn;
    logic [ALIGN_W-1:0] r_str [N_CH];

    logic [N_CH-1:0]    w_req [N_GRP];
    logic [N_GRP-1:0]   w_match, r_match, r_match_q, w_event, w_adv, w_qual;
    logic [DIV_W-1:0]   r_pre [N_GRP];
    logic [DIV_W-1:0]   w_pre_nx [N_GRP];
    logic [DIV_W-1:0]   w_div1 [N_GRP];
    logic [CNT_W-1:0]   r_cnt [N_GRP];

    state_t             r_state;
    logic               r_trg;
    logic [N_GRP-1:0]   r_tag;
    logic [DEAD_CW-1:0] r_dead;
    logic [DEAD_W-1:0]  w_dt1;
    logic [DEAD_CW-1:0] w_dead_load;

    assign w_sel  = (bus.hit_ab_sel_in & ~bus.hit_b_in_N) | (~bus.hit_ab_sel_in & ~bus.hit_a_in_N);
    assign w_edge = r_s2 & ~r_s3 & ~bus.hit_mask_in;

    // Two-flop synchroniser plus one delay flop for rising-edge detection
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= w_sel;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Per-channel stretch down-counter; a re-trigger reloads rather than accumulates
    always_ff @(posedge clk_in) begin
        for (int c = 0; c < N_CH; c++) begin
            if (rst_in || bus.hit_mask_in[c]) begin
                r_str[c] <= '0;
            end else if (w_edge[c]) begin
                r_str[c] <= (bus.hit_align_in[c*ALIGN_W +: ALIGN_W] == '0) ?
                            ALIGN_W'(1) : bus.hit_align_in[c*ALIGN_W +: ALIGN_W];
            end else if (r_str[c] != '0) begin
                r_str[c] <= r_str[c] - ALIGN_W'(1);
            end
        end
    end

    // Stretched hit level per channel
    always_comb begin
        w_hit_syn = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_hit_syn[c] = (r_str[c] != '0);
        end
    end

    // Group match, event edge, prescaler advance and qualification
    always_comb begin
        w_match = '0;
        w_adv   = '0;
        w_qual  = '0;
        w_event = r_match & ~r_match_q;
        for (int g = 0; g < N_GRP; g++) begin
            w_req[g]    = bus.grp_mux_in[g*N_CH +: N_CH] & ~bus.hit_mask_in;
            w_match[g]  = (w_req[g] != '0) && ((w_hit_syn & w_req[g]) == w_req[g]);
            w_div1[g]   = (bus.grp_div_in[g*DIV_W +: DIV_W] == '0) ?
                          DIV_W'(1) : bus.grp_div_in[g*DIV_W +: DIV_W];
            w_pre_nx[g] = r_pre[g] + DIV_W'(1);
            w_adv[g]    = w_event[g] && (r_state == S_IDLE) && !bus.busy_in && bus.grp_oe_in[g];
            w_qual[g]   = w_adv[g] && (w_pre_nx[g] == w_div1[g]);
        end
    end

    // Registered group match, its delayed copy, raw counters and prescalers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_match   <= '0;
            r_match_q <= '0;
            for (int g = 0; g < N_GRP; g++) begin
                r_cnt[g] <= '0;
                r_pre[g] <= '0;
            end
        end else begin
            r_match   <= w_match;
            r_match_q <= r_match;
            for (int g = 0; g < N_GRP; g++) begin
                if (w_event[g] && (r_cnt[g] != '1)) begin
                    r_cnt[g] <= r_cnt[g] + CNT_W'(1);
                end
                if (w_qual[g]) begin
                    r_pre[g] <= '0;
                end else if (w_adv[g]) begin
                    r_pre[g] <= w_pre_nx[g];
                end
            end
        end
    end

    assign w_dt1       = (bus.trg_dead_time_in == '0) ? DEAD_W'(1) : bus.trg_dead_time_in;
    assign w_dead_load = DEAD_CW'(32'(w_dt1) * 32'(DEAD_UNIT) - 32'd1);

    // Trigger FSM with registered pulse, tag and dead-time counter
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_trg   <= 1'b0;
            r_tag   <= '0;
            r_dead  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_trg <= 1'b0;
                    if (w_qual != '0) begin
                        r_state <= S_TRIG;
                        r_trg   <= 1'b1;
                        r_tag   <= w_qual;
                    end
                end
                S_TRIG: begin
                    r_trg   <= 1'b0;
                    r_dead  <= w_dead_load;
                    r_state <= S_DEAD;
                end
                S_DEAD: begin
                    r_trg <= 1'b0;
                    if (r_dead != '0) begin
                        r_dead <= r_dead - DEAD_CW'(1);
                    end else if (!bus.busy_in) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_trg   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hit_syn_out     = w_hit_syn;
    assign bus.grp_match_out   = r_match;
    assign bus.coincid_trg_out = r_trg;
    assign bus.coincid_tag_out = r_tag;
    assign bus.busy_out        = bus.busy_in || (r_state != S_IDLE);

    // Flatten raw counters onto the output bus
    always_comb begin
        bus.grp_cnt_out = '0;
        for (int g = 0; g < N_GRP; g++) begin
            bus.grp_cnt_out[g*CNT_W +: CNT_W] = r_cnt[g];
        end
    end
endmodule

// File: tb/tb_coincid_trig_core.sv
// Directed bench for coincid_trig_core; counters built 4 bits wide so saturation is reachable.
module tb_coincid_trig_core;
    localparam int N_CH      = 8;
    localparam int N_GRP     = 5;
    localparam int ALIGN_W   = 4;
    localparam int DIV_W     = 6;
    localparam int CNT_W     = 4;
    localparam int DEAD_W    = 8;
    localparam int DEAD_UNIT = 500;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    coincid_trig_core_if #(.N_CH(N_CH), .N_GRP(N_GRP), .ALIGN_W(ALIGN_W), .DIV_W(DIV_W),
                           .CNT_W(CNT_W), .DEAD_W(DEAD_W)) bus ();

    coincid_trig_core #(.N_CH(N_CH), .N_GRP(N_GRP), .ALIGN_W(ALIGN_W), .DIV_W(DIV_W),
                        .CNT_W(CNT_W), .DEAD_W(DEAD_W), .DEAD_UNIT(DEAD_UNIT)) u_dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic set_hit(input int ch, input bit lb, input bit lvl);
        if (lb) bus.hit_b_in_N[ch] = lvl;
        else    bus.hit_a_in_N[ch] = lvl;
    endtask

    // Hold a line low for 4 cycles, watch n cycles, count trigger pulses and keep last tag
    task automatic pulse_watch(input int ch, input bit lb, input int n,
                               output int n_trg, output logic [N_GRP-1:0] tag);
        n_trg = 0;
        tag   = '0;
        set_hit(ch, lb, 1'b0);
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (bus.coincid_trg_out === 1'b1) begin
                n_trg++;
                tag = bus.coincid_tag_out;
            end
            if (i == 3) set_hit(ch, lb, 1'b1);
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && bus.busy_out !== 1'b0; i++) tick(1);
        n_cmp++;
        if (bus.busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy_out=%b required 0 within %0d cycles", bus.busy_out, max_cyc);
        end
    endtask

    task automatic init_cfg();
        bus.hit_a_in_N       = '1;
        bus.hit_b_in_N       = '1;
        bus.hit_ab_sel_in    = '0;
        bus.hit_mask_in      = '0;
        bus.hit_align_in     = {N_CH{4'd3}};
        bus.busy_in          = 1'b0;
        bus.grp_mux_in       = '0;
        bus.grp_oe_in        = '0;
        bus.grp_div_in       = {N_GRP{6'd1}};
        bus.trg_dead_time_in = 8'd1;
    endtask

    task automatic test_reset();
        init_cfg();
        bus.busy_in = 1'b1;
        rst = 1'b1;
        tick(2);
        n_cmp++;
        if (bus.busy_out !== 1'b1) begin
            n_err++; $display("FAIL reset_busy_follow: busy_out=%b required 1", bus.busy_out);
        end
        bus.busy_in = 1'b0;
        rst = 1'b0;
        tick(1);
        n_cmp++;
        if ({bus.hit_syn_out, bus.grp_match_out, bus.coincid_trg_out, bus.coincid_tag_out, bus.busy_out} !== '0) begin
            n_err++; $display("FAIL reset_outputs: syn=%h match=%h trg=%b tag=%h busy=%b required all 0",
                              bus.hit_syn_out, bus.grp_match_out, bus.coincid_trg_out, bus.coincid_tag_out, bus.busy_out);
        end
        n_cmp++;
        if (bus.grp_cnt_out !== '0) begin
            n_err++; $display("FAIL reset_cnt: grp_cnt=%h required 0", bus.grp_cnt_out);
        end
    endtask

    task automatic test_single();
        int cnt;
        int n_trg;
        apply_reset();
        bus.grp_mux_in[0 +: N_CH] = 8'h01;
        bus.grp_oe_in = 5'h01;
        bus.hit_a_in_N[0] = 1'b0;
        tick(2);
        n_cmp++;
        if (bus.hit_syn_out[0] !== 1'b0) begin
            n_err++; $display("FAIL single_syn_early: hit_syn[0]=%b required 0", bus.hit_syn_out[0]);
        end
        tick(1);
        n_cmp++;
        if (bus.hit_syn_out[0] !== 1'b1) begin
            n_err++; $display("FAIL single_syn_k3: hit_syn[0]=%b required 1", bus.hit_syn_out[0]);
        end
        tick(1);
        n_cmp++;
        if (bus.grp_match_out !== 5'h01 || bus.coincid_trg_out !== 1'b0) begin
            n_err++; $display("FAIL single_k4: match=%h trg=%b required 01/0", bus.grp_match_out, bus.coincid_trg_out);
        end
        tick(1);
        n_cmp++;
        if (bus.coincid_trg_out !== 1'b1 || bus.coincid_tag_out !== 5'h01 || bus.hit_syn_out[0] !== 1'b1) begin
            n_err++; $display("FAIL single_k5: trg=%b tag=%h syn0=%b required 1/01/1",
                              bus.coincid_trg_out, bus.coincid_tag_out, bus.hit_syn_out[0]);
        end
        tick(1);
        n_cmp++;
        if (bus.coincid_trg_out !== 1'b0 || bus.hit_syn_out[0] !== 1'b0 || bus.busy_out !== 1'b1) begin
            n_err++; $display("FAIL single_k6: trg=%b syn0=%b busy=%b required 0/0/1",
                              bus.coincid_trg_out, bus.hit_syn_out[0], bus.busy_out);
        end
        cnt = 0;
        n_trg = 0;
        while (bus.busy_out === 1'b1 && cnt < 1000) begin
            if (cnt == 4)  bus.hit_a_in_N[0] = 1'b1;
            if (cnt == 20) bus.hit_a_in_N[0] = 1'b0;
            if (cnt == 25) bus.hit_a_in_N[0] = 1'b1;
            tick(1);
            cnt++;
            if (bus.coincid_trg_out === 1'b1) n_trg++;
        end
        n_cmp++;
        if (cnt != 500 || n_trg != 0) begin
            n_err++; $display("FAIL single_dead: busy cycles=%0d trg=%0d required 500/0", cnt, n_trg);
        end
        n_cmp++;
        if (bus.grp_cnt_out[0 +: CNT_W] !== 4'd2) begin
            n_err++; $display("FAIL single_cnt: grp_cnt0=%0d required 2", bus.grp_cnt_out[0 +: CNT_W]);
        end
    endtask

    task automatic test_ab_mask();
        int n_trg;
        logic [N_GRP-1:0] tag;
        apply_reset();
        bus.grp_mux_in = '0;
        bus.grp_mux_in[1*N_CH +: N_CH] = 8'h02;
        bus.grp_oe_in = 5'h02;
        bus.hit_ab_sel_in[1] = 1'b1;
        pulse_watch(1, 1'b0, 12, n_trg, tag);
        n_cmp++;
        if (n_trg != 0) begin
            n_err++; $display("FAIL ab_line_a: trg=%0d required 0", n_trg);
        end
        pulse_watch(1, 1'b1, 12, n_trg, tag);
        n_cmp++;
        if (n_trg != 1 || tag !== 5'h02) begin
            n_err++; $display("FAIL ab_line_b: trg=%0d tag=%h required 1/02", n_trg, tag);
        end
        wait_idle(600);
        bus.hit_mask_in[1] = 1'b1;
        pulse_watch(1, 1'b1, 12, n_trg, tag);
        n_cmp++;
        if (n_trg != 0 || bus.grp_cnt_out[1*CNT_W +: CNT_W] !== 4'd1) begin
            n_err++; $display("FAIL mask_block: trg=%0d cnt1=%0d required 0/1", n_trg, bus.grp_cnt_out[1*CNT_W +: CNT_W]);
        end
        bus.grp_mux_in[1*N_CH +: N_CH] = 8'h03;
        pulse_watch(0, 1'b0, 12, n_trg, tag);
        n_cmp++;
        if (n_trg != 1 || tag !== 5'h02 || bus.grp_cnt_out[1*CNT_W +: CNT_W] !== 4'd2) begin
            n_err++; $display("FAIL mask_reduce: trg=%0d tag=%h cnt1=%0d required 1/02/2",
                              n_trg, tag, bus.grp_cnt_out[1*CNT_W +: CNT_W]);
        end
        wait_idle(600);
        bus.hit_mask_in = '0;
        bus.hit_ab_sel_in = '0;
    endtask

    task automatic test_prescaler();
        int n_trg;
        logic [N_GRP-1:0] tag;
        apply_reset();
        bus.grp_mux_in = '0;
        bus.grp_mux_in[0 +: N_CH] = 8'h01;
        bus.grp_oe_in = 5'h01;
        bus.grp_div_in[0 +: DIV_W] = 6'd2;
        for (int e = 1; e <= 6; e++) begin
            pulse_watch(0, 1'b0, 20, n_trg, tag);
            n_cmp++;
            if (n_trg != ((e % 2 == 0) ? 1 : 0)) begin
                n_err++; $display("FAIL prescale_ev%0d: trg=%0d required %0d", e, n_trg, (e % 2 == 0) ? 1 : 0);
            end
            wait_idle(600);
        end
        n_cmp++;
        if (bus.grp_cnt_out[0 +: CNT_W] !== 4'd6) begin
            n_err++; $display("FAIL prescale_cnt: grp_cnt0=%0d required 6", bus.grp_cnt_out[0 +: CNT_W]);
        end
        bus.grp_div_in = {N_GRP{6'd1}};
    endtask

    task automatic test_back_to_back_busy();
        int n_trg;
        logic [N_GRP-1:0] tag;
        apply_reset();
        bus.grp_mux_in = '0;
        bus.grp_mux_in[0 +: N_CH]    = 8'h01;
        bus.grp_mux_in[1*N_CH +: N_CH] = 8'h01;
        bus.grp_oe_in = 5'h03;
        pulse_watch(0, 1'b0, 20, n_trg, tag);
        n_cmp++;
        if (n_trg != 1 || tag !== 5'h03) begin
            n_err++; $display("FAIL simul_tag: trg=%0d tag=%h required 1/03", n_trg, tag);
        end
        bus.busy_in = 1'b1;
        tick(600);
        pulse_watch(0, 1'b0, 20, n_trg, tag);
        n_cmp++;
        if (n_trg != 0 || bus.grp_cnt_out[0 +: CNT_W] !== 4'd2 || bus.grp_cnt_out[1*CNT_W +: CNT_W] !== 4'd2) begin
            n_err++; $display("FAIL busy_events: trg=%0d cnt0=%0d cnt1=%0d required 0/2/2",
                              n_trg, bus.grp_cnt_out[0 +: CNT_W], bus.grp_cnt_out[1*CNT_W +: CNT_W]);
        end
        bus.busy_in = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy_out !== 1'b1) begin
            n_err++; $display("FAIL busy_hold_dead: busy_out=%b required 1", bus.busy_out);
        end
        tick(1);
        n_cmp++;
        if (bus.busy_out !== 1'b0) begin
            n_err++; $display("FAIL busy_release: busy_out=%b required 0", bus.busy_out);
        end
    endtask

    task automatic test_saturation();
        int n_trg;
        int tot;
        logic [N_GRP-1:0] tag;
        apply_reset();
        bus.grp_mux_in = '0;
        bus.grp_mux_in[2*N_CH +: N_CH] = 8'h04;
        bus.grp_oe_in = 5'h00;
        tot = 0;
        for (int e = 1; e <= 20; e++) begin
            pulse_watch(2, 1'b0, 12, n_trg, tag);
            tot += n_trg;
            if (e == 14) begin
                n_cmp++;
                if (bus.grp_cnt_out[2*CNT_W +: CNT_W] !== 4'd14) begin
                    n_err++; $display("FAIL sat_14: grp_cnt2=%0d required 14", bus.grp_cnt_out[2*CNT_W +: CNT_W]);
                end
            end
        end
        n_cmp++;
        if (bus.grp_cnt_out[2*CNT_W +: CNT_W] !== 4'd15 || tot != 0) begin
            n_err++; $display("FAIL sat_20: grp_cnt2=%0d trg=%0d required 15/0", bus.grp_cnt_out[2*CNT_W +: CNT_W], tot);
        end
    endtask

    task automatic test_mid_reset();
        int n_trg;
        logic [N_GRP-1:0] tag;
        apply_reset();
        bus.grp_mux_in = '0;
        bus.grp_mux_in[0 +: N_CH] = 8'h01;
        bus.grp_oe_in = 5'h01;
        pulse_watch(0, 1'b0, 20, n_trg, tag);
        tick(100);
        n_cmp++;
        if (n_trg != 1 || bus.busy_out !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre: trg=%0d busy=%b required 1/1", n_trg, bus.busy_out);
        end
        apply_reset();
        n_cmp++;
        if (bus.busy_out !== 1'b0 || bus.coincid_tag_out !== '0 || bus.grp_cnt_out !== '0) begin
            n_err++; $display("FAIL midrst_clear: busy=%b tag=%h cnt=%h required 0/0/0",
                              bus.busy_out, bus.coincid_tag_out, bus.grp_cnt_out);
        end
        bus.hit_a_in_N[0] = 1'b0;
        tick(4);
        n_cmp++;
        if (bus.coincid_trg_out !== 1'b0) begin
            n_err++; $display("FAIL midrst_early: trg=%b required 0", bus.coincid_trg_out);
        end
        tick(1);
        n_cmp++;
        if (bus.coincid_trg_out !== 1'b1 || bus.coincid_tag_out !== 5'h01) begin
            n_err++; $display("FAIL midrst_lat5: trg=%b tag=%h required 1/01", bus.coincid_trg_out, bus.coincid_tag_out);
        end
        bus.hit_a_in_N[0] = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_ab_mask();
        test_prescaler();
        test_back_to_back_busy();
        test_saturation();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/coincid_trig_core.md
Name: coincid_trig_core

Overview:
Parametrised successor to the fixed-width coincidence block. It takes N_CH redundant (a/b) active-low hit channels and a busy input. Per channel it synchronises the hit, selects the a or b line, masks it and stretches it by a programmable alignment window. It then evaluates N_GRP configurable AND-logic groups, each with a per-group prescaler, and issues a single tagged trigger followed by a programmable dead time. It sits between the FEE hit inputs and the trigger distribution / readout logic.

Parameters:
N_CH, 8, number of hit channels (each has an a and a b line)
N_GRP, 5, number of logic groups
ALIGN_W, 4, width of each per-channel alignment (stretch) value
DIV_W, 6, width of each per-group prescale divisor
CNT_W, 16, width of each per-group raw event counter
DEAD_W, 8, width of the dead-time setting
DEAD_UNIT, 500, clk_in cycles per dead-time unit (10 us at 50 MHz)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
hit_a_in_N  in  N_CH  active-low hit, line a, per channel
hit_b_in_N  in  N_CH  active-low hit, line b, per channel
hit_ab_sel_in  in  N_CH  per channel: 0 selects a, 1 selects b
hit_mask_in  in  N_CH  1 = channel disabled
hit_align_in  in  N_CH*ALIGN_W  per-channel stretch length in cycles; 0 is treated as 1
busy_in  in  1  active-high external busy veto
grp_mux_in  in  N_GRP*N_CH  per group: required-channel bitmap
grp_oe_in  in  N_GRP  group trigger enable
grp_div_in  in  N_GRP*DIV_W  per-group prescale divisor; 0 is treated as 1
trg_dead_time_in  in  DEAD_W  dead time in DEAD_UNITs; 0 is treated as 1
hit_syn_out  out  N_CH  stretched, masked channel hits
grp_match_out  out  N_GRP  registered group match level
coincid_trg_out  out  1  one-cycle trigger pulse
coincid_tag_out  out  N_GRP  groups that caused the trigger; held until the next trigger
grp_cnt_out  out  N_GRP*CNT_W  raw group event counters, saturating
busy_out  out  1  high in TRIG or DEAD state, or while busy_in is high

Behaviour:
- Reset (synchronous, rst_in=1 at a clk_in edge) clears:
  - all synchroniser and stretcher registers, prescalers and raw counters;
  - all outputs to 0, except busy_out, which follows busy_in;
  - the FSM, which goes to IDLE.
- A reset asserted mid-DEAD or mid-stretch aborts immediately.
- Input stage, per channel:
  - sel = hit_ab_sel_in ? ~hit_b_in_N : ~hit_a_in_N;
  - sel passes through a 2-FF synchroniser (s1, s2) plus a delay FF s3;
  - edge = s2 & ~s3 & ~mask.
- Stretcher, per channel:
  - on edge, the down-counter loads max(align,1);
  - hit_syn_out is high while the counter is nonzero;
  - a re-trigger while active reloads the counter (window is extended, not summed);
  - setting mask=1 clears the counter in the next cycle.
- Group logic:
  - req[g] = grp_mux[g] & ~hit_mask;
  - match[g] = (req[g] != 0) && ((hit_syn & req[g]) == req[g]);
  - grp_match_out[g] is match registered;
  - event[g] = rising edge of grp_match_out[g];
  - a group whose required channels are all masked never matches.
- Raw counter: grp_cnt[g] increments on every event[g], independent of state, busy and oe, and saturates at all-ones.
- Prescaler, per group:
  - it advances only on event[g] with FSM=IDLE, busy_in=0 and grp_oe[g]=1;
  - qual[g] is asserted when the advanced count equals max(div,1), and the count then resets to 0;
  - otherwise the count holds.
  - Events arriving in TRIG/DEAD, during busy, or with oe=0 are dropped without advancing.
- FSM states: IDLE, TRIG, DEAD.
  - IDLE→TRIG when any qual; the tag register latches qual.
  - TRIG lasts 1 cycle with coincid_trg_out=1, then goes to DEAD with the dead counter loaded to max(trg_dead_time_in,1)*DEAD_UNIT−1.
  - DEAD decrements the counter; at 0 it goes to IDLE only if busy_in=0, otherwise it holds at 0 until busy_in falls.
- Simultaneous qualification: all qualifying groups are tagged in one trigger and all their prescalers reset.
- Latency: an input asserted and sampled at edge k gives:
  - hit_syn_out high at k+3;
  - grp_match_out at k+4;
  - coincid_trg_out at k+5 (fixed).
- Configuration inputs are treated as quasi-static. A change to trg_dead_time_in takes effect at the next trigger.

Test Plan:
- Reset check: all hit lines idle, rst_in pulse → after reset, all outputs 0 and grp_cnt_out all zeros.
- Single channel:
  - setup: ch0 line a low for 10 cycles, align=3, grp0 mux=0x01, div=1, oe=0x01, dead=1;
  - hit_syn_out[0] high for exactly 3 cycles starting at k+3;
  - coincid_trg_out pulses at k+5 with tag=0x01;
  - the next trigger is blocked for 500 cycles.
- A/B select and mask:
  - with ch1 sel=1, only hit_b triggers;
  - with hit_mask[1]=1 and grp1 mux=0x02, there is no trigger and no count;
  - with grp1 mux=0x03 and ch1 masked, a ch0 hit alone triggers.
- Prescaler: div=2, 6 separated events (spacing > dead time) → exactly 3 triggers (events 2, 4, 6), grp_cnt=6.
- Simultaneous groups and busy:
  - grp0 and grp1 qualify in the same cycle → one pulse, tag=0x03;
  - holding busy_in high through the end of DEAD keeps the FSM in DEAD, and events then raise grp_cnt without producing triggers;
  - busy_in falls → IDLE on the next cycle.
- Saturation and mid-operation reset:
  - with CNT_W=4, 20 events → grp_cnt=15;
  - rst_in asserted mid-DEAD → IDLE, and a new hit triggers immediately with 5-cycle latency.
